memory_dbus_access: RTL and testbench

//  Memory-stage data-bus access unit. Downstream of the store-data lane selector:

---
 rtl/memory_dbus_access.sv | 165 ++++++++++++++++
 tb/tb_memory_dbus_access.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dbus_access.sv
// Memory-stage data-bus access unit: issues one dbus request per aligned memory op,
// stalls the pipeline through the addr_ok/data_ok handshake and returns the extended load word.
module memory_dbus_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [1:0]  mem_msize,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_busy,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        misalign_err,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data
);

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        latch_en;
    logic        capture_en;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic        lat_signed;
    logic [31:0] cap_data;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MSIZE1:  is_misaligned = 1'b0;
            MSIZE2:  is_misaligned = lo[0];
            MSIZE4:  is_misaligned = (lo != 2'd0);
            default: is_misaligned = (lo != 2'd0);
        endcase
    endfunction

    function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MSIZE1:  strobe_of = 4'b0001 << lo;
            MSIZE2:  strobe_of = 4'b0011 << lo;
            MSIZE4:  strobe_of = 4'b1111;
            default: strobe_of = 4'b1111;
        endcase
    endfunction

    // Right-justify the addressed bytes, then sign- or zero-extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] lo,
                                                input logic [1:0] size, input logic sgn);
        logic [31:0] w;
        w = raw >> {lo, 3'b000};
        case (size)
            MSIZE1:  extend_load = sgn ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            MSIZE2:  extend_load = sgn ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            MSIZE4:  extend_load = w;
            default: extend_load = w;
        endcase
    endfunction

    // State register plus request latches and load-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_size   <= 2'd0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            cap_data   <= 32'd0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                lat_addr   <= mem_addr;
                lat_wdata  <= mem_wdata;
                lat_size   <= mem_msize;
                lat_write  <= mem_write;
                lat_signed <= mem_signed;
            end
            if (capture_en) begin
                cap_data <= lat_write ? 32'd0
                                      : extend_load(dresp_data, lat_addr[1:0], lat_size, lat_signed);
            end
        end
    end

    // Next-state and handshake decode; data_ok is only honoured once addr_ok has been seen.
    always_comb begin
        state_next   = state;
        mem_busy     = 1'b0;
        misalign_err = 1'b0;
        dreq_valid   = 1'b0;
        result_valid = 1'b0;
        latch_en     = 1'b0;
        capture_en   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (is_misaligned(mem_msize, mem_addr[1:0])) begin
                        misalign_err = 1'b1;
                    end else begin
                        mem_busy   = 1'b1;
                        latch_en   = 1'b1;
                        state_next = ADDR;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ADDR: begin
                dreq_valid = 1'b1;
                mem_busy   = 1'b1;
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        capture_en = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = DATA;
                    end
                end else begin
                    state_next = ADDR;
                end
            end
            DATA: begin
                mem_busy = 1'b1;
                if (dresp_data_ok) begin
                    capture_en = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = DATA;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result_data = result_valid ? cap_data : 32'd0;
    assign dreq_addr   = lat_addr;
    assign dreq_size   = lat_size;
    assign dreq_data   = lat_wdata;
    assign dreq_strobe = lat_write ? strobe_of(lat_size, lat_addr[1:0]) : 4'b0000;

endmodule

// File: tb/tb_memory_dbus_access.sv
// Randomized scoreboard bench for memory_dbus_access with a byte-arithmetic reference model
// and a bus responder that varies addr_ok/data_ok timing per transaction.
module tb_memory_dbus_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_write, mem_signed;
    logic [1:0]  mem_msize;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_busy, result_valid, misalign_err, dreq_valid;
    logic [31:0] result_data, dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          misal;
        logic [31:0] data;
        int          cycle;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    memory_dbus_access dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_msize(mem_msize),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .result_valid(result_valid), .result_data(result_data),
        .misalign_err(misalign_err), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [31:0] addr,
                                               input logic [1:0] s, input bit sgn);
        int          n;
        logic [63:0] v;
        logic [63:0] one;
        n   = nbytes(s);
        one = 64'd1;
        v   = ({32'd0, raw} >> (8 * (addr % 4))) & ((one << (8 * n)) - one);
        if (sgn && n < 4 && v >= (one << (8 * n - 1)))
            v = v - (one << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strobe(input bit wr, input logic [31:0] addr,
                                                input logic [1:0] s);
        int          n;
        logic [31:0] m;
        if (!wr) return 4'b0000;
        n = nbytes(s);
        m = ((32'd1 << n) - 32'd1) << (addr % 4);
        return m[3:0];
    endfunction

    // Monitor: every result or misalign pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (result_valid || misalign_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {30'd0, result_valid, misalign_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_kind", {31'd0, misalign_err}, {31'd0, mon_e.misal});
                check("out_cycle", cyc, mon_e.cycle);
                if (!mon_e.misal) check("result_data", result_data, mon_e.data);
            end
        end
    end

    // One memory op with a bus that answers addr_ok after ad cycles and data_ok dd cycles later.
    task automatic do_op(input bit wr, input logic [1:0] sz, input bit sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ad, input int dd, input bit spurious);
        exp_t e;
        int   c0;
        mem_valid  = 1'b1;
        mem_write  = wr;
        mem_msize  = sz;
        mem_signed = sgn;
        mem_addr   = addr;
        mem_wdata  = wdata;
        dresp_data = $urandom;
        c0 = cyc;
        e.misal = (addr % nbytes(sz)) != 0;
        if (e.misal) begin
            e.data  = 32'd0;
            e.cycle = c0;
            sb.push_back(e);
            @(negedge clk);
            check("misal_busy", {31'd0, mem_busy}, 32'd0);
            check("misal_dreq", {31'd0, dreq_valid}, 32'd0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            return;
        end
        e.data  = wr ? 32'd0 : model_load(rdata, addr, sz, sgn);
        e.cycle = c0 + 2 + ad + dd;
        sb.push_back(e);
        @(negedge clk);
        check("issue_busy", {31'd0, mem_busy}, 32'd1);
        @(posedge clk); #1;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_msize = 2'($urandom_range(0, 2));
        mem_write = ~wr;
        for (int i = 0; i <= ad; i++) begin
            dresp_addr_ok = (i == ad);
            dresp_data_ok = (i == ad) ? (dd == 0) : (spurious && i == 0);
            dresp_data    = (i == ad && dd == 0) ? rdata : $urandom;
            @(negedge clk);
            check("addr_dreq_valid", {31'd0, dreq_valid}, 32'd1);
            check("addr_busy", {31'd0, mem_busy}, 32'd1);
            check("dreq_addr", dreq_addr, addr);
            check("dreq_size", {30'd0, dreq_size}, {30'd0, sz});
            check("dreq_strobe", {28'd0, dreq_strobe}, {28'd0, model_strobe(wr, addr, sz)});
            check("dreq_data", dreq_data, wdata);
            @(posedge clk); #1;
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        for (int j = 1; j <= dd; j++) begin
            dresp_data_ok = (j == dd);
            dresp_data    = (j == dd) ? rdata : $urandom;
            @(negedge clk);
            check("data_dreq_valid", {31'd0, dreq_valid}, 32'd0);
            check("data_busy", {31'd0, mem_busy}, 32'd1);
            @(posedge clk); #1;
        end
        dresp_data_ok = 1'b0;
        @(negedge clk);
        check("done_busy", {31'd0, mem_busy}, 32'd0);
        check("done_valid", {31'd0, result_valid}, 32'd1);
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1;
        mem_valid = 1'b0; mem_write = 1'b0; mem_signed = 1'b0; mem_msize = 2'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {28'd0, mem_busy, result_valid, misalign_err, dreq_valid}, 32'd0);
        check("reset_dreq", dreq_addr | dreq_data | {28'd0, dreq_strobe} | {30'd0, dreq_size}, 32'd0);
        check("reset_result", result_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0, 32'h80FF_FFFF, 0, 0, 1'b0);
        do_op(1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'hBEEF_0000, 32'd0, 3, 2, 1'b1);
        do_op(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'd0, 32'd0, 0, 0, 1'b0);
        do_op(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'd0, 32'h8001_1234, 1, 1, 1'b0);

        // Reset while waiting for data_ok; the late data_ok must produce nothing.
        mem_valid = 1'b1; mem_write = 1'b0; mem_msize = 2'd2; mem_addr = 32'h0000_0100;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_valid = 1'b0;
        #1;
        check("rst_mid_dreq", {31'd0, dreq_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        dresp_data_ok = 1'b1;
        dresp_data = 32'h1234_5678;
        @(negedge clk);
        check("late_data_ok_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        check("late_data_ok_result", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 0, 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
